// File: rtl/reg_write_arbiter_pkg.sv
// Shared FSM encoding and requester indices for register-bank write arbiters.
// No logic of its own: combinational constants only, no backpressure.
package reg_write_arbiter_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOAD = 1'b1
    } state_t;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant, purely combinational (0 cycles): prio wins ties.
// No grant while enable is low; grant only ever follows a raised valid.
module rr_arbiter2
    import reg_write_arbiter_pkg::*;
(
    input  logic [1:0] valid,
    input  logic       prio,
    input  logic       enable,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        if (enable) begin
            grant[REQ0] = valid[REQ0] && (!valid[REQ1] || (prio == REQ0));
            grant[REQ1] = valid[REQ1] && (!valid[REQ0] || (prio == REQ1));
        end
    end

endmodule

// File: rtl/reg_write_arbiter.sv
// Shares a register bank's write port between two requesters, round-robin; strobe one cycle after accept.
// Accepts at most one write per 2 cycles; ready is low throughout LOAD so requesters simply hold valid.
module reg_write_arbiter
    import reg_write_arbiter_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int NUM_REGS = 8,
    parameter int ADDR_W   = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req0_valid,
    input  logic [ADDR_W-1:0]   req0_addr,
    input  logic [WIDTH-1:0]    req0_data,
    output logic                req0_ready,
    input  logic                req1_valid,
    input  logic [ADDR_W-1:0]   req1_addr,
    input  logic [WIDTH-1:0]    req1_data,
    output logic                req1_ready,
    output logic [NUM_REGS-1:0] reg_load,
    output logic [WIDTH-1:0]    reg_in,
    output logic                busy,
    output logic                addr_err
);

    state_t               state;
    logic                 prio;
    logic [1:0]           grant;
    logic                 accept;
    logic [ADDR_W-1:0]    sel_addr;
    logic [WIDTH-1:0]     sel_data;
    logic [NUM_REGS-1:0]  sel_onehot;

    // Ready is gated by rst_n so nothing looks accepted while reset is held.
    rr_arbiter2 u_arb (
        .valid  ({req1_valid, req0_valid}),
        .prio   (prio),
        .enable ((state == ST_IDLE) && rst_n),
        .grant  (grant)
    );

    assign req0_ready = grant[REQ0];
    assign req1_ready = grant[REQ1];
    assign accept     = |grant;

    always_comb begin
        sel_addr = req0_addr;
        sel_data = req0_data;
        if (grant[REQ1]) begin
            sel_addr = req1_addr;
            sel_data = req1_data;
        end
    end

    // Out-of-range addresses match no bit, which doubles as the error detect.
    always_comb begin
        sel_onehot = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            sel_onehot[k] = (sel_addr == ADDR_W'(k));
        end
    end

    // reg_in is the data latch itself, so it keeps the last written value while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            prio     <= REQ0;
            reg_load <= '0;
            reg_in   <= '0;
            busy     <= 1'b0;
            addr_err <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state    <= ST_LOAD;
                        prio     <= grant[REQ0] ? REQ1 : REQ0;
                        reg_in   <= sel_data;
                        reg_load <= sel_onehot;
                        busy     <= 1'b1;
                        addr_err <= ~|sel_onehot;
                    end
                end
                ST_LOAD: begin
                    state    <= ST_IDLE;
                    reg_load <= '0;
                    busy     <= 1'b0;
                    addr_err <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter with a behavioural register bank on its outputs.
module tb_reg_write_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req1_valid;
    logic [3:0]  req0_addr, req1_addr;
    logic [31:0] req0_data, req1_data;
    logic        req0_ready, req1_ready;
    logic [7:0]  reg_load;
    logic [31:0] reg_in;
    logic        busy, addr_err;

    logic        bank_clr;
    logic [31:0] bank [8];
    logic [31:0] exp_bank [8];
    int          load4_cnt = 0;
    int          cnt0;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    reg_write_arbiter #(.WIDTH(32), .NUM_REGS(8), .ADDR_W(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_addr  (req0_addr),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_addr  (req1_addr),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .reg_load   (reg_load),
        .reg_in     (reg_in),
        .busy       (busy),
        .addr_err   (addr_err)
    );

    // Register bank is not reset by rst_n, so a lost write stays visible.
    always @(posedge clk) begin
        for (int k = 0; k < 8; k++) begin
            if (bank_clr) bank[k] <= '0;
            else if (reg_load[k]) bank[k] <= reg_in;
        end
        if (reg_load[4]) load4_cnt <= load4_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int r, input logic v, input logic [3:0] a, input logic [31:0] d);
        if (r == 0) begin
            req0_valid = v; req0_addr = a; req0_data = d;
        end else begin
            req1_valid = v; req1_addr = a; req1_data = d;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        bank_clr = 1'b1;
        for (int k = 0; k < 8; k++) exp_bank[k] = '0;
        set_req(0, 1'b1, 4'd2, 32'h0);
        set_req(1, 1'b0, 4'd0, 32'h0);
        tick(); tick();
        check("rst_ready0", {31'b0, req0_ready}, 32'd0);
        check("rst_ready1", {31'b0, req1_ready}, 32'd0);
        check("rst_load", {24'b0, reg_load}, 32'd0);
        check("rst_reg_in", reg_in, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_addr_err", {31'b0, addr_err}, 32'd0);
        req0_valid = 1'b0;
        bank_clr = 1'b0;
        rst_n = 1'b1;

        // Single write
        set_req(0, 1'b1, 4'd2, 32'h12345678);
        #1 check("single_ready0", {31'b0, req0_ready}, 32'd1);
        check("single_ready1", {31'b0, req1_ready}, 32'd0);
        tick();
        check("single_load", {24'b0, reg_load}, 32'h04);
        check("single_reg_in", reg_in, 32'h12345678);
        check("single_busy", {31'b0, busy}, 32'd1);
        check("single_ready_in_load", {31'b0, req0_ready}, 32'd0);
        req0_valid = 1'b0;
        tick();
        check("single_bank2", bank[2], 32'h12345678);
        check("single_busy_done", {31'b0, busy}, 32'd0);
        check("single_load_done", {24'b0, reg_load}, 32'd0);
        exp_bank[2] = 32'h12345678;

        // Reset during LOAD; prio was 1 before the reset
        set_req(0, 1'b1, 4'd3, 32'hFFFFAAAA);
        #1 check("rmid_ready0", {31'b0, req0_ready}, 32'd1);
        tick();
        check("rmid_load", {24'b0, reg_load}, 32'h08);
        req0_valid = 1'b0;
        rst_n = 1'b0;
        #1 check("rmid_load_drop", {24'b0, reg_load}, 32'd0);
        check("rmid_reg_in", reg_in, 32'd0);
        check("rmid_busy", {31'b0, busy}, 32'd0);
        check("rmid_addr_err", {31'b0, addr_err}, 32'd0);
        tick();
        check("rmid_bank3", bank[3], 32'd0);
        rst_n = 1'b1;

        // Contention: prio back at 0 after reset
        set_req(0, 1'b1, 4'd1, 32'hA);
        set_req(1, 1'b1, 4'd5, 32'hB);
        #1 check("cont0_ready0", {31'b0, req0_ready}, 32'd1);
        check("cont0_ready1", {31'b0, req1_ready}, 32'd0);
        tick();
        check("cont0_load", {24'b0, reg_load}, 32'h02);
        check("cont0_no_ready", {30'b0, req1_ready, req0_ready}, 32'd0);
        tick();
        check("cont2_ready1", {31'b0, req1_ready}, 32'd1);
        check("cont2_ready0", {31'b0, req0_ready}, 32'd0);
        tick();
        check("cont2_load", {24'b0, reg_load}, 32'h20);
        tick();
        check("cont4_ready0", {31'b0, req0_ready}, 32'd1);
        check("cont4_ready1", {31'b0, req1_ready}, 32'd0);
        tick();
        check("cont4_load", {24'b0, reg_load}, 32'h02);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();
        check("cont_bank1", bank[1], 32'hA);
        check("cont_bank5", bank[5], 32'hB);
        exp_bank[1] = 32'hA;
        exp_bank[5] = 32'hB;

        // Same-address race, prio is 1
        cnt0 = load4_cnt;
        set_req(1, 1'b1, 4'd4, 32'h1111);
        set_req(0, 1'b1, 4'd4, 32'h2222);
        #1 check("race_ready1", {31'b0, req1_ready}, 32'd1);
        check("race_ready0", {31'b0, req0_ready}, 32'd0);
        tick();
        check("race_load_a", {24'b0, reg_load}, 32'h10);
        check("race_data_a", reg_in, 32'h1111);
        req1_valid = 1'b0;
        tick();
        check("race_ready0_2", {31'b0, req0_ready}, 32'd1);
        tick();
        check("race_load_b", {24'b0, reg_load}, 32'h10);
        req0_valid = 1'b0;
        tick();
        check("race_bank4", bank[4], 32'h2222);
        check("race_pulses", 32'(load4_cnt - cnt0), 32'd2);
        exp_bank[4] = 32'h2222;

        // Bad address from req1
        set_req(1, 1'b1, 4'd9, 32'hDEAD);
        #1 check("bad_ready1", {31'b0, req1_ready}, 32'd1);
        tick();
        check("bad_addr_err", {31'b0, addr_err}, 32'd1);
        check("bad_load", {24'b0, reg_load}, 32'd0);
        check("bad_busy", {31'b0, busy}, 32'd1);
        req1_valid = 1'b0;
        tick();
        check("bad_addr_err_clr", {31'b0, addr_err}, 32'd0);
        for (int k = 0; k < 8; k++) check($sformatf("bad_bank%0d", k), bank[k], exp_bank[k]);

        // prio must now be 0: req0 wins the tie
        set_req(0, 1'b1, 4'd6, 32'hCAFE);
        set_req(1, 1'b1, 4'd7, 32'hBEEF);
        #1 check("idle_prio0_ready0", {31'b0, req0_ready}, 32'd1);
        check("idle_prio0_ready1", {31'b0, req1_ready}, 32'd0);
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();
        check("idle_bank6", bank[6], 32'hCAFE);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("idle_load", {24'b0, reg_load}, 32'd0);
            check("idle_reg_in", reg_in, 32'hCAFE);
            check("idle_busy", {31'b0, busy}, 32'd0);
        end
        set_req(0, 1'b1, 4'd0, 32'h1);
        set_req(1, 1'b1, 4'd0, 32'h2);
        #1 check("idle_prio_ready1", {31'b0, req1_ready}, 32'd1);
        check("idle_prio_ready0", {31'b0, req0_ready}, 32'd0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/reg_write_arbiter.md
Name: reg_write_arbiter

Overview:
- Shares the write port of a bank of NUM_REGS `register` instances between two requesters.
- Arbitrates round-robin and accepts one write per handshake.
- Drives the one-hot load strobe and shared data bus into the bank one cycle after acceptance.
- Sits between the CPU/DMA write sources and the register bank. Reads bypass this block.

Parameters:
- WIDTH, 32, data width of each register and of reg_in.
- NUM_REGS, 8, number of registers in the bank (2..16).
- ADDR_W, 4, request address width; must satisfy 2**ADDR_W >= NUM_REGS.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req0_valid  in  1  requester 0 has a write pending.
- req0_addr  in  ADDR_W  requester 0 target register index.
- req0_data  in  WIDTH  requester 0 write data.
- req0_ready  out  1  requester 0 write accepted this cycle.
- req1_valid  in  1  requester 1 has a write pending.
- req1_addr  in  ADDR_W  requester 1 target register index.
- req1_data  in  WIDTH  requester 1 write data.
- req1_ready  out  1  requester 1 write accepted this cycle.
- reg_load  out  NUM_REGS  one-hot load strobes, bit k drives load of register k.
- reg_in  out  WIDTH  shared data bus to every register's in.
- busy  out  1  high while a write is in LOAD state.
- addr_err  out  1  one-cycle pulse: accepted request had addr >= NUM_REGS.

Behaviour:
- Reset (rst_n low, takes effect immediately):
  - state=IDLE, prio=0.
  - reg_load=0, reg_in=0, busy=0, addr_err=0, req0_ready=req1_ready=0.
- States:
  - IDLE: accepting.
  - LOAD: strobe asserted for exactly one cycle.
- Grant in IDLE (combinational from valids and prio):
  - Only one valid: that requester is granted.
  - Both valid: requester == prio is granted.
  - reqN_ready = (state==IDLE) && grantN; never high in LOAD.
  - At most one ready high in any cycle.
- Handshake: reqN_valid && reqN_ready at a rising edge = accepted. On that edge:
  - addr/data latched into internal regs.
  - prio <= other requester.
  - state <= LOAD.
- prio changes only on acceptance; with no acceptance it holds.
- LOAD cycle (cycle after acceptance):
  - reg_load = one-hot of latched addr.
  - reg_in = latched data.
  - busy=1.
  - Next edge: register captures, state <= IDLE.
- Latency and throughput:
  - Target register output shows new data after the 2nd rising edge following acceptance.
  - Max throughput is one write per 2 cycles.
- Outside LOAD: reg_load=0, reg_in holds last written data (not zeroed).
- Out-of-range address (addr >= NUM_REGS):
  - Still accepted (ready high, prio advances).
  - LOAD cycle occurs with reg_load=0 and addr_err=1 for that cycle only.
  - No register changes.
- Valid withdrawn before ready: no effect; no state change.
- Same address from both requesters back-to-back: both writes occur in grant order; the later one wins.
- Reset asserted during LOAD: reg_load drops immediately, write is lost, prio returns to 0.
- reg_load and reg_in are driven from flops, not from request inputs (no input-to-bank combinational path).

Decomposition:
- Shared package/header holds:
  - state encoding localparams ST_IDLE=1'b0, ST_LOAD=1'b1.
  - requester index constants REQ0=0, REQ1=1.
- One natural sub-module: rr_arbiter2 (inputs valid[1:0], prio, enable; output grant[1:0]), purely combinational and reused by later bank arbiters.
- Latch, FSM and one-hot decode stay in reg_write_arbiter.

Test Plan:
- Reset mid-operation:
  - Stimulus: rst_n=0 for 2 cycles then 1; req0 writes addr 3 = 32'hFFFFAAAA; assert rst_n=0 during its LOAD cycle.
  - Required: all outputs 0 immediately; register 3 unchanged; after release, next simultaneous request is granted to req0.
- Single write:
  - Stimulus: req0 valid addr=2 data=32'h12345678.
  - Required: req0_ready=1 in the IDLE cycle; next cycle reg_load=8'b00000100, reg_in=32'h12345678, busy=1; register 2 reads 32'h12345678 two edges after acceptance; req0_ready=0 during LOAD.
- Contention:
  - Stimulus: req0 (addr 1, 32'hA) and req1 (addr 5, 32'hB) both held valid.
  - Required: grants alternate req0, req1, req0 on accept cycles 0, 2, 4; reg_load sequence 8'h02, 8'h20, 8'h02.
- Same-address race:
  - Stimulus: req1 addr 4 = 32'h1111, then req0 addr 4 = 32'h2222, both valid from same cycle with prio=1.
  - Required: register 4 ends at 32'h2222; exactly two reg_load[4] pulses.
- Bad address:
  - Stimulus: NUM_REGS=8, req1 addr=4'd9 data=32'hDEAD.
  - Required: req1_ready=1; next cycle addr_err=1, reg_load=0, busy=1; no register changes; prio now 0.
- Idle hold:
  - Stimulus: no valids for 10 cycles after a write of 32'hCAFE.
  - Required: reg_load stays 0, reg_in stays 32'hCAFE, prio unchanged, busy=0.
